pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall controller for the 5-stage 8-bit RISC pipeline (IF, ID, EX, MEM, WB). It decodes the instruction in ID and tracks destination registers for the instructions in EX and MEM in its own scoreboard. On a read-after-write hazard it freezes PC and IF/ID and injects a bubble into ID/EX. It also sequences run start and end-of-program drain, and keeps hazard statistics.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.
- `HAZ_CNT_W`, default 8: width of the saturating hazard-event counter.
- `clk` input 1: single clock; everything is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a run; ignored unless the block is in IDLE or DONE.
- `fetch_done` input 1: fetch has delivered the last instruction into ID; sampled in RUN only.
- `id_valid` input 1: `id_instr` holds a real instruction; when 0 it is treated as noop.
- `id_instr` input 8: instruction currently in ID.
- `pc_en` output 1: PC update enable.
- `ifid_en` output 1: IF/ID register load enable.
- `idex_bubble` output 1: load noop into ID/EX this cycle.
- `stall` output 1: hazard stall is active this cycle.
- `busy` output 1: the block is in RUN, STALL or DRAIN.
- `done` output 1: the pipeline has drained after `fetch_done`.
- `stall_cycles` output `STALL_CNT_W`: saturating count of stall cycles in the current run.
- `hazard_events` output `HAZ_CNT_W`: saturating count of distinct stall episodes in the current run.

## Operation
- Instruction format: opcode [7:6], A = [5:3], B = [2:0]. Opcodes: 00 noop, 01 add, 10 sw, 11 lw.
- Decode per opcode:
  - add: sources A and B; destination A.
  - lw: source B (address); destination A.
  - sw: sources A (data) and B (address); no destination.
  - noop: no sources; no destination.
- r0 (000) is never a hazard. A destination of r0 is recorded as "no destination".
- Scoreboard: slots `ex_dst` and `mem_dst`, each holding a valid bit and a 3-bit register. No forwarding. The register file writes in WB before ID reads, so WB never causes a hazard.
- Hazard: a valid ID instruction has a source that equals a valid `ex_dst` or `mem_dst`.
- States:
  - IDLE: outputs quiet. `start` moves to RUN and clears both counters and the scoreboard.
  - RUN: if a hazard is present, go to STALL in the same cycle (the outputs are combinational). Otherwise advance. `fetch_done` with no hazard goes to DRAIN.
  - STALL: stays while the hazard is present; returns to RUN when it clears. A latched `fetch_done` is honoured on exit.
  - DRAIN: `pc_en` = 0 and `ifid_en` = 0, bubbles are injected, and the scoreboard keeps shifting. Go to DONE when both slots are invalid.
  - DONE: `done` = 1 and is held until `start` or reset; `start` goes to RUN.
- `fetch_done` that arrives during a hazard is latched in a pending flag. DRAIN begins on the cycle the hazard clears; the instruction in ID issues first.
- Scoreboard update, every cycle in RUN, STALL or DRAIN: `mem_dst` <= `ex_dst`. `ex_dst` <= the ID destination when the instruction issues, otherwise invalid (bubble).
- Counters:
  - `stall_cycles` increments on every STALL cycle.
  - `hazard_events` increments on the RUN->STALL transition.
  - Both saturate at all-ones.

## Timing
- Reset values:
  - `pc_en` = 0, `ifid_en` = 0, `idex_bubble` = 1, `stall` = 0, `busy` = 0, `done` = 0.
  - Counters = 0, scoreboard invalid, state IDLE, pending flag = 0.
- In RUN with no hazard: `pc_en` = 1, `ifid_en` = 1, `idex_bubble` = 0.
- During a hazard: `pc_en` = 0, `ifid_en` = 0, `idex_bubble` = 1, `stall` = 1.
- Stall decisions are combinational from `id_instr` and the scoreboard in the same cycle. State, scoreboard and counters are registered.
- Hazard latency:
  - Match on `ex_dst`: 2 stall cycles.
  - Match on `mem_dst` only: 1 stall cycle.
  - This follows from re-evaluating every cycle; no explicit timer.
- Simultaneous matches on `ex_dst` and `mem_dst`: the `ex_dst` match governs, giving 2 cycles total.
- `start` while `busy`: ignored.
- `rst_n` low mid-run: on the next edge everything returns to reset values. No partial drain.
- `id_valid` = 0: noop; it never stalls and issues as a bubble.

## Test plan
- Back-to-back dependency:
  - Stimulus: 0x4A (add r1,r2), then 0x59 (add r3,r1).
  - Required: `stall` high exactly 2 cycles, `stall_cycles` = 2, `hazard_events` = 1, then 0x59 issues.
- Distance-2 dependency:
  - Stimulus: 0xD4 (lw r2,(r4)), 0x00, 0x95 (sw r2,(r5)).
  - Required: 1 stall cycle on 0x95, `stall_cycles` = 1.
- No-hazard stream:
  - Stimulus: 0x4A, 0xD4 (lw r2,(r4)), 0x00, 0x40 (add r0,r0).
  - Required: `stall` never asserts, `pc_en` = 1 in every RUN cycle, counters stay 0.
  - Note: the pair 0x4A then 0x59 must not appear in this stream, because it hazards on r1.
- Drain with a pending hazard:
  - Stimulus: assert `fetch_done` in the same cycle 0x59 stalls behind 0x4A.
  - Required: 0x59 issues after 2 stalls. DRAIN then runs until the scoreboard is empty. `done` rises 2 cycles after entering DRAIN and holds.
- Saturation and reset:
  - Stimulus: force more than 2^`STALL_CNT_W` stall cycles with `STALL_CNT_W` = 4, then pulse `rst_n` low mid-stall.
  - Required: `stall_cycles` holds at 15. After reset all outputs equal their reset values and the state is IDLE.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW-hazard stall controller for the 5-stage 8-bit RISC pipeline.
// Decodes the ID instruction, tracks EX/MEM destinations in a two-slot scoreboard,
// freezes PC and IF/ID on a hazard, sequences run start and end-of-program drain,
// and keeps saturating stall statistics for the current run.
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned HAZ_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   fetch_done,
    input  logic                   id_valid,
    input  logic [7:0]             id_instr,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_bubble,
    output logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [HAZ_CNT_W-1:0]   hazard_events
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOOP = 2'b00,
        OP_ADD  = 2'b01,
        OP_SW   = 2'b10,
        OP_LW   = 2'b11
    } opcode_t;

    state_t     state;
    state_t     state_nx;

    opcode_t    op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       use_a;
    logic       use_b;
    logic       dst_v;
    logic       hit_a;
    logic       hit_b;
    logic       in_flow;
    logic       active;
    logic       hazard;
    logic       issue;
    logic       launch;

    logic       ex_v;
    logic [2:0] ex_r;
    logic       mem_v;
    logic [2:0] mem_r;
    logic       pend;

    // Decode the ID instruction and compare its sources against the scoreboard
    always_comb begin
        op      = opcode_t'(id_instr[7:6]);
        ra      = id_instr[5:3];
        rb      = id_instr[2:0];
        use_a   = id_valid && (op == OP_ADD || op == OP_SW) && (ra != 3'd0);
        use_b   = id_valid && (op != OP_NOOP) && (rb != 3'd0);
        dst_v   = id_valid && (op == OP_ADD || op == OP_LW) && (ra != 3'd0);
        hit_a   = use_a && ((ex_v && ex_r == ra) || (mem_v && mem_r == ra));
        hit_b   = use_b && ((ex_v && ex_r == rb) || (mem_v && mem_r == rb));
        in_flow = (state == S_RUN) || (state == S_STALL);
        active  = in_flow || (state == S_DRAIN);
        hazard  = in_flow && (hit_a || hit_b);
        issue   = in_flow && !hazard;
        launch  = start && ((state == S_IDLE) || (state == S_DONE));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; DRAIN exits once the shift leaves both slots empty,
    // which is the case exactly when the EX slot is already empty
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_RUN;
            S_RUN: begin
                if (hazard)          state_nx = S_STALL;
                else if (fetch_done) state_nx = S_DRAIN;
            end
            S_STALL: if (!hazard) state_nx = pend ? S_DRAIN : S_RUN;
            S_DRAIN: if (!ex_v) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from state and the combinational hazard
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        stall       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            S_RUN, S_STALL: begin
                busy = 1'b1;
                if (hazard) begin
                    stall = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Scoreboard: MEM takes EX, EX takes the issuing destination or a bubble
    always_ff @(posedge clk) begin
        if (!rst_n || launch) begin
            ex_v  <= 1'b0;
            ex_r  <= '0;
            mem_v <= 1'b0;
            mem_r <= '0;
        end else if (active) begin
            mem_v <= ex_v;
            mem_r <= ex_r;
            ex_v  <= issue && dst_v;
            ex_r  <= (issue && dst_v) ? ra : '0;
        end
    end

    // Pending end-of-fetch seen while stalled, honoured when the stall clears
    always_ff @(posedge clk) begin
        if (!rst_n || launch) begin
            pend <= 1'b0;
        end else if (state == S_RUN && hazard && fetch_done) begin
            pend <= 1'b1;
        end else if (state == S_STALL && !hazard) begin
            pend <= 1'b0;
        end
    end

    // Saturating statistics, cleared at the start of each run
    always_ff @(posedge clk) begin
        if (!rst_n || launch) begin
            stall_cycles  <= '0;
            hazard_events <= '0;
        end else begin
            if (hazard && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
            if (state == S_RUN && hazard && hazard_events != '1) begin
                hazard_events <= hazard_events + HAZ_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table, directed corner sequences and
// random stimulus, all checked against a register-ready-time reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned SCW   = 4;
    localparam int unsigned HCW   = 3;
    localparam int          SCMAX = (1 << SCW) - 1;
    localparam int          HCMAX = (1 << HCW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           fetch_done;
    logic           id_valid;
    logic [7:0]     id_instr;
    logic           pc_en;
    logic           ifid_en;
    logic           idex_bubble;
    logic           stall;
    logic           busy;
    logic           done;
    logic [SCW-1:0] stall_cycles;
    logic [HCW-1:0] hazard_events;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .STALL_CNT_W(SCW),
        .HAZ_CNT_W  (HCW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fetch_done   (fetch_done),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_bubble  (idex_bubble),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles),
        .hazard_events(hazard_events)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a register is unreadable until three cycles after the
    // cycle its producer issued; the run is a set of flags plus a drain deadline.
    bit m_act, m_drain, m_done, m_pend, m_prevst;
    int m_cyc;
    int m_ready[8];
    int m_dend;
    int m_sc, m_hz;

    logic [5:0] obs_vec, exp_vec;
    int         obs_sc, obs_hz;

    typedef struct {
        bit         st;
        bit         fd;
        bit         v;
        logic [7:0] ins;
        logic [5:0] ev;
        int         sc;
        int         hz;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    function automatic void m_reset();
        m_act = 0; m_drain = 0; m_done = 0; m_pend = 0; m_prevst = 0;
        m_sc = 0; m_hz = 0; m_dend = 0;
        for (int r = 0; r < 8; r++) m_ready[r] = 0;
    endfunction

    function automatic bit m_hazard(input bit v, input logic [7:0] ins);
        logic [1:0] op;
        int a, b;
        bit h;
        op = ins[7:6];
        a  = int'(ins[5:3]);
        b  = int'(ins[2:0]);
        h  = 0;
        if (!m_act || !v) return 0;
        if ((op == 2'b01 || op == 2'b10) && a != 0 && m_ready[a] > m_cyc) h = 1;
        if (op != 2'b00 && b != 0 && m_ready[b] > m_cyc) h = 1;
        return h;
    endfunction

    function automatic void m_update(input bit st, input bit fd, input bit v,
                                     input logic [7:0] ins, input bit rn, input bit h);
        int a;
        a = int'(ins[5:3]);
        if (!rn) begin
            m_reset();
        end else if (m_act) begin
            if (h) begin
                if (m_sc < SCMAX) m_sc++;
                if (!m_prevst) begin
                    if (m_hz < HCMAX) m_hz++;
                    if (fd) m_pend = 1;
                end
                m_prevst = 1;
            end else begin
                if (v && (ins[7:6] == 2'b01 || ins[7:6] == 2'b11) && a != 0)
                    m_ready[a] = m_cyc + 3;
                if (m_pend || (fd && !m_prevst)) begin
                    m_act   = 0;
                    m_drain = 1;
                    m_pend  = 0;
                    m_dend  = m_cyc + 2;
                    for (int r = 0; r < 8; r++)
                        if (m_ready[r] > m_dend) m_dend = m_ready[r];
                end
                m_prevst = 0;
            end
        end else if (m_drain) begin
            if (m_cyc + 1 >= m_dend) begin
                m_drain = 0;
                m_done  = 1;
            end
        end else if (st) begin
            m_reset();
            m_act = 1;
        end
        m_cyc++;
    endfunction

    // One clock: drive, sample at the falling edge against the model, advance.
    task automatic step(input bit st, input bit fd, input bit v,
                        input logic [7:0] ins, input bit rn);
        bit h;
        start      = st;
        fetch_done = fd;
        id_valid   = v;
        id_instr   = ins;
        rst_n      = rn;
        @(negedge clk);
        h = m_hazard(v, ins);
        if (m_act)        exp_vec = h ? 6'b001110 : 6'b110010;
        else if (m_drain) exp_vec = 6'b001010;
        else              exp_vec = {5'b00100, m_done};
        obs_vec = {pc_en, ifid_en, idex_bubble, stall, busy, done};
        obs_sc  = int'(stall_cycles);
        obs_hz  = int'(hazard_events);
        chk("model_ctrl", int'(obs_vec), int'(exp_vec));
        chk("model_stall_cycles", obs_sc, m_sc);
        chk("model_hazard_events", obs_hz, m_hz);
        @(posedge clk);
        m_update(st, fd, v, ins, rn, h);
        #1;
    endtask

    initial begin
        // {start, fetch_done, id_valid, instr, {pc_en,ifid_en,bubble,stall,busy,done}, stall_cycles, hazard_events}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b001000, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h4A, 6'b110010, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h59, 6'b001110, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h59, 6'b001110, 1, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h59, 6'b110010, 2, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b110010, 2, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'hD4, 6'b110010, 2, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b110010, 2, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h95, 6'b001110, 2, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h95, 6'b110010, 3, 2};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 6'b110010, 3, 2};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h4A, 6'b001010, 3, 2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b001001, 3, 2};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h59, 6'b001001, 3, 2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b001001, 3, 2};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h4A, 6'b110010, 0, 0};

        start = 0; fetch_done = 0; id_valid = 0; id_instr = '0; rst_n = 0;
        m_cyc = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
        chk("reset_ctrl", int'(obs_vec), int'(6'b001000));
        chk("reset_stall_cycles", obs_sc, 0);
        chk("reset_hazard_events", obs_hz, 0);

        // Vector table: back-to-back, distance-2, drain, done hold, restart
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].st, tbl[i].fd, tbl[i].v, tbl[i].ins, 1'b1);
            chk($sformatf("tbl%0d_ctrl", i), int'(obs_vec), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_stall_cycles", i), obs_sc, tbl[i].sc);
            chk($sformatf("tbl%0d_hazard_events", i), obs_hz, tbl[i].hz);
        end

        // No-hazard stream from a fresh run
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        foreach (tbl[k]) begin
            logic [7:0] ins;
            if (k >= 4) break;
            ins = (k == 0) ? 8'h4A : (k == 1) ? 8'hD4 : (k == 2) ? 8'h00 : 8'h40;
            step(1'b0, 1'b0, 1'b1, ins, 1'b1);
            chk($sformatf("nohaz%0d_ctrl", k), int'(obs_vec), int'(6'b110010));
        end
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("nohaz_stall_cycles", obs_sc, 0);
        chk("nohaz_hazard_events", obs_hz, 0);

        // Drain with fetch_done arriving on the stall cycle
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h4A, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h59, 1'b1);
        chk("pend_stall1", int'(obs_vec), int'(6'b001110));
        step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
        chk("pend_stall2", int'(obs_vec), int'(6'b001110));
        step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
        chk("pend_issue", int'(obs_vec), int'(6'b110010));
        step(1'b0, 1'b0, 1'b1, 8'h4A, 1'b1);
        chk("pend_drain1", int'(obs_vec), int'(6'b001010));
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("pend_drain2", int'(obs_vec), int'(6'b001010));
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("pend_done", int'(obs_vec), int'(6'b001001));
        step(1'b0, 1'b1, 1'b1, 8'h59, 1'b1);
        chk("pend_done_hold", int'(obs_vec), int'(6'b001001));
        chk("pend_stall_cycles", obs_sc, 2);
        chk("pend_hazard_events", obs_hz, 1);

        // Saturation: 10 episodes of 2 stalls, then reset in the middle of a stall
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int r = 0; r < 10; r++) begin
            step(1'b0, 1'b0, 1'b1, 8'h4A, 1'b1);
            step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
            step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
            step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
        end
        chk("sat_stall_cycles", obs_sc, 15);
        chk("sat_hazard_events", obs_hz, 7);
        step(1'b0, 1'b0, 1'b1, 8'h4A, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
        chk("sat_still15", obs_sc, 15);
        step(1'b0, 1'b0, 1'b1, 8'h59, 1'b0);
        chk("sat_midstall", int'(obs_vec), int'(6'b001110));
        step(1'b0, 1'b1, 1'b1, 8'h59, 1'b1);
        chk("rst_ctrl", int'(obs_vec), int'(6'b001000));
        chk("rst_stall_cycles", obs_sc, 0);
        chk("rst_hazard_events", obs_hz, 0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);
        chk("rst_restart_run", int'(obs_vec), int'(6'b110010));

        // Random stimulus, small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [7:0] ins;
            bit st, fd, v, rn;
            ins = 8'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                ins[5] = 1'b0;
                ins[2] = 1'b0;
            end
            st = ($urandom_range(0, 11) == 0);
            fd = ($urandom_range(0, 14) == 0);
            v  = ($urandom_range(0, 7) != 0);
            rn = ($urandom_range(0, 149) != 0);
            step(st, fd, v, ins, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
